// File: rtl/ecc_pkg.sv
// ECC block shared types: opcodes, codeword modes, sequencer states
// and the codeword width mask helper.
package ecc_pkg;

    typedef enum logic [1:0] {
        OP_ENC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_CHAN = 2'd2,
        OP_ILL  = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        CW_8   = 2'd0,
        CW_16  = 2'd1,
        CW_32  = 2'd2,
        CW_ILL = 2'd3
    } cw_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENC_WAIT = 3'd1,
        ST_CHAN     = 3'd2,
        ST_DEC_WAIT = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

    function automatic logic [31:0] width_mask(input cw_mode_e mode);
        logic [31:0] m;
        case (mode)
            CW_8:    m = 32'h0000_00FF;
            CW_16:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ecc_op_sequencer_wdog.sv
// Engine watchdog: counts enabled cycles, flags expiry on the
// TIMEOUT_CYC-th cycle of a wait; clear returns it to zero.
module ecc_wdog_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired = enable && (cnt_q == W'(TIMEOUT_CYC - 1));

    // next count: hold at expiry, restart on clear
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ecc_op_sequencer.sv
// ECC operation sequencer: latches a CTRL command and runs the
// encode / decode / full-channel flow against the ENC and DEC engines.
module ecc_op_sequencer
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            opcode,
    input  logic [1:0]            cw_mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] noise,
    output logic                  enc_start,
    output logic [DATA_WIDTH-1:0] enc_data,
    input  logic                  enc_done,
    input  logic [DATA_WIDTH-1:0] enc_result,
    output logic                  dec_start,
    output logic [DATA_WIDTH-1:0] dec_data,
    input  logic                  dec_done,
    input  logic [DATA_WIDTH-1:0] dec_result,
    input  logic [1:0]            dec_num_err,
    output logic [1:0]            enc_dec_mode,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors,
    output logic                  op_error,
    output logic                  busy,
    output logic                  start_dropped
);

    seq_state_e            state_q, state_d;
    opcode_e               op_q, op_d;
    cw_mode_e              mode_q, mode_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] noise_q, noise_d;
    logic [DATA_WIDTH-1:0] enc_res_q, enc_res_d;
    logic [DATA_WIDTH-1:0] dec_data_q, dec_data_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]            nerr_q, nerr_d;
    logic                  enc_start_q, enc_start_d;
    logic                  dec_start_q, dec_start_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  dropped_q, dropped_d;

    logic                  in_wait;
    logic                  wd_expired;
    logic [DATA_WIDTH-1:0] mask;

    assign in_wait = (state_q == ST_ENC_WAIT) || (state_q == ST_DEC_WAIT);
    assign mask    = DATA_WIDTH'(width_mask(mode_q));

    ecc_wdog_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (wd_expired)
    );

    assign enc_start      = enc_start_q;
    assign enc_data       = din_q;
    assign dec_start      = dec_start_q;
    assign dec_data       = dec_data_q;
    assign enc_dec_mode   = mode_q;
    assign data_out       = data_out_q;
    assign operation_done = done_q;
    assign num_of_errors  = nerr_q;
    assign op_error       = err_q;
    assign busy           = (state_q != ST_IDLE);
    assign start_dropped  = dropped_q;

    // sequencer next-state, operand latching and handshake pulses
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mode_d      = mode_q;
        din_d       = din_q;
        noise_d     = noise_q;
        enc_res_d   = enc_res_q;
        dec_data_d  = dec_data_q;
        data_out_d  = data_out_q;
        nerr_d      = nerr_q;
        enc_start_d = 1'b0;
        dec_start_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dropped_d   = start && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = opcode_e'(opcode);
                    mode_d  = cw_mode_e'(cw_mode);
                    din_d   = data_in;
                    noise_d = noise;
                    if (opcode == OP_ILL || cw_mode == CW_ILL) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (opcode == OP_DEC) begin
                        state_d     = ST_DEC_WAIT;
                        dec_start_d = 1'b1;
                        dec_data_d  = data_in;
                    end else begin
                        state_d     = ST_ENC_WAIT;
                        enc_start_d = 1'b1;
                    end
                end
            end
            ST_ENC_WAIT: begin
                if (enc_done) begin
                    enc_res_d = enc_result;
                    if (op_q == OP_ENC) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        data_out_d = enc_result;
                        nerr_d     = 2'd0;
                    end else begin
                        state_d = ST_CHAN;
                    end
                end else if (wd_expired) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_CHAN: begin
                state_d     = ST_DEC_WAIT;
                dec_start_d = 1'b1;
                dec_data_d  = (enc_res_q ^ noise_q) & mask;
            end
            ST_DEC_WAIT: begin
                if (dec_done) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    data_out_d = dec_result;
                    nerr_d     = dec_num_err;
                end else if (wd_expired) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, latched operands and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ENC;
            mode_q      <= CW_8;
            din_q       <= '0;
            noise_q     <= '0;
            enc_res_q   <= '0;
            dec_data_q  <= '0;
            data_out_q  <= '0;
            nerr_q      <= 2'd0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mode_q      <= mode_d;
            din_q       <= din_d;
            noise_q     <= noise_d;
            enc_res_q   <= enc_res_d;
            dec_data_q  <= dec_data_d;
            data_out_q  <= data_out_d;
            nerr_q      <= nerr_d;
            enc_start_q <= enc_start_d;
            dec_start_q <= dec_start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dropped_q   <= dropped_d;
        end
    end

endmodule
